jpeg_block_loader: RTL



---
 rtl/jpeg_block_loader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/jpeg_block_loader.sv
// Assembles 32-bit AXI-Stream pixel words into 8x8 blocks using two ping-pong buffers.
// Each completed block is presented as one wide word with a valid/ready handshake.
`timescale 1ns/1ps
module jpeg_block_loader #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INPUT_WIDTH = 8,
  parameter int unsigned DATA_DEPTH  = 8,
  parameter int unsigned PIXEL_COUNT = DATA_DEPTH * DATA_DEPTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_WIDTH-1:0]              s_axis_tdata,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  input  logic                               s_axis_tlast,
  output logic [PIXEL_COUNT*INPUT_WIDTH-1:0] blk_data,
  output logic                               blk_valid,
  input  logic                               blk_ready,
  output logic                               blk_last,
  output logic                               tlast_err,
  input  logic                               err_clr,
  output logic [15:0]                        blk_count
);

  localparam int unsigned PPW = DATA_WIDTH / INPUT_WIDTH;
  localparam int unsigned WPB = PIXEL_COUNT / PPW;
  localparam int unsigned WCW = (WPB > 1) ? $clog2(WPB) : 1;
  localparam logic [WCW-1:0] WLast = WCW'(WPB - 1);

  logic [1:0]          full_q, full_d;
  logic [1:0]          last_q, last_d;
  logic [1:0][WPB-1:0] mask_q, mask_d;
  logic [WCW-1:0]      wcnt_q, wcnt_d;
  logic                fill_sel_q, fill_sel_d;
  logic                drain_sel_q, drain_sel_d;
  logic [15:0]         blk_count_q, blk_count_d;
  logic                tlast_err_q, tlast_err_d;
  logic                tready_q, tready_d;
  logic [DATA_WIDTH-1:0] mem_q [2][WPB];

  logic accept, close, early, handoff;

  assign accept  = s_axis_tvalid && tready_q;
  assign early   = accept && s_axis_tlast && (wcnt_q != WLast);
  assign close   = accept && (s_axis_tlast || (wcnt_q == WLast));
  assign handoff = full_q[drain_sel_q] && blk_ready;

  always_comb begin
    full_d      = full_q;
    last_d      = last_q;
    mask_d      = mask_q;
    wcnt_d      = wcnt_q;
    fill_sel_d  = fill_sel_q;
    drain_sel_d = drain_sel_q;
    blk_count_d = blk_count_q;
    tlast_err_d = tlast_err_q;

    if (accept) begin
      mask_d[fill_sel_q][wcnt_q] = 1'b1;
      wcnt_d = wcnt_q + WCW'(1);
    end
    if (close) begin
      full_d[fill_sel_q] = 1'b1;
      last_d[fill_sel_q] = s_axis_tlast;
      wcnt_d             = '0;
      fill_sel_d         = ~fill_sel_q;
    end
    // Fill and drain can never target the same buffer in one cycle: fill needs it empty,
    // handoff needs it full.
    if (handoff) begin
      full_d[drain_sel_q] = 1'b0;
      last_d[drain_sel_q] = 1'b0;
      mask_d[drain_sel_q] = '0;
      drain_sel_d         = ~drain_sel_q;
      blk_count_d         = blk_count_q + 16'd1;
    end

    if (early) begin
      tlast_err_d = 1'b1;
    end else if (err_clr) begin
      tlast_err_d = 1'b0;
    end

    // Registered ready keeps it low during reset without a path from the reset pin.
    tready_d = !full_d[fill_sel_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q      <= '0;
      last_q      <= '0;
      mask_q      <= '0;
      wcnt_q      <= '0;
      fill_sel_q  <= 1'b0;
      drain_sel_q <= 1'b0;
      blk_count_q <= '0;
      tlast_err_q <= 1'b0;
      tready_q    <= 1'b0;
    end else begin
      full_q      <= full_d;
      last_q      <= last_d;
      mask_q      <= mask_d;
      wcnt_q      <= wcnt_d;
      fill_sel_q  <= fill_sel_d;
      drain_sel_q <= drain_sel_d;
      blk_count_q <= blk_count_d;
      tlast_err_q <= tlast_err_d;
      tready_q    <= tready_d;
    end
  end

  // Pixel storage carries no reset; the word masks decide what is visible.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[fill_sel_q][wcnt_q] <= s_axis_tdata;
    end
  end

  always_comb begin
    blk_data = '0;
    for (int w = 0; w < WPB; w++) begin
      blk_data[w*DATA_WIDTH +: DATA_WIDTH] =
          mask_q[drain_sel_q][w] ? mem_q[drain_sel_q][w] : '0;
    end
  end

  assign s_axis_tready = tready_q;
  assign blk_valid     = full_q[drain_sel_q];
  assign blk_last      = last_q[drain_sel_q];
  assign blk_count     = blk_count_q;
  assign tlast_err     = tlast_err_q;

endmodule
